// File: rtl/ld_violation_tracker.sv
// ld_violation_tracker
//
// Tracks the oldest outstanding load-ordering violation reported by the
// memory-lane writeback stage. Once that load reaches the active-list head
// and is ready to commit, the block raises a one-cycle recovery request.
// It then holds off until the core's recovery flag is seen. It also keeps a
// saturating count of accepted violation packets for the performance counters.
//
// State table:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_IDLE     | nothing tracked
//   ST_HELD     | oldest violation held, waiting for it to reach the head
//   ST_FIRE     | recoverReq_o asserted for this single cycle
//   ST_WAIT_REC | request issued, waiting for recoverFlag_i to flush us
//
// Ports:
//   clk            core clock
//   reset          synchronous active-high reset
//   recoverFlag_i  core-wide recovery in progress, flushes tracked state
//   ldVioValid_i   load-violation packet valid
//   ldVioSeqNo_i   sequence number of the violating load
//   ldVioAlID_i    active-list index of the violating load
//   headAlID_i     alID currently at the active-list head
//   headReady_i    head entry would commit this cycle
//   violateValid_o a violation is being tracked
//   violateAlID_o  alID of the tracked violation (0 when idle)
//   recoverReq_o   one-cycle load-violation flush request
//   vioCount_o     saturating count of accepted violation packets

module ld_violation_tracker #(
    parameter int SEQ_W = 8,
    parameter int AL_W  = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recoverFlag_i,
    input  logic             ldVioValid_i,
    input  logic [SEQ_W-1:0] ldVioSeqNo_i,
    input  logic [AL_W-1:0]  ldVioAlID_i,
    input  logic [AL_W-1:0]  headAlID_i,
    input  logic             headReady_i,
    output logic             violateValid_o,
    output logic [AL_W-1:0]  violateAlID_o,
    output logic             recoverReq_o,
    output logic [CNT_W-1:0] vioCount_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_FIRE     = 2'd2,
        ST_WAIT_REC = 2'd3
    } state_e;

    state_e           state_q;
    logic [SEQ_W-1:0] seq_q;
    logic [AL_W-1:0]  alid_q;
    logic             valid_q;
    logic             req_q;
    logic [CNT_W-1:0] cnt_q;

    logic [SEQ_W-1:0] seq_diff_d;
    logic             in_older_d;
    logic             head_match_d;
    logic             cnt_sat_d;

    // The incoming load is older when the modular distance (in - held) has its
    // MSB set. Equal sequence numbers give zero, so they do not count as older.
    always_comb begin
        seq_diff_d   = ldVioSeqNo_i - seq_q;
        in_older_d   = seq_diff_d[SEQ_W-1];
        head_match_d = headReady_i && (headAlID_i == alid_q);
        cnt_sat_d    = &cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            alid_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (recoverFlag_i) begin
            // Flush squashes any same-cycle packet, and the count is kept.
            state_q <= ST_IDLE;
            seq_q   <= '0;
            alid_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            if (ldVioValid_i && !cnt_sat_d) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            req_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ldVioValid_i) begin
                        seq_q   <= ldVioSeqNo_i;
                        alid_q  <= ldVioAlID_i;
                        valid_q <= 1'b1;
                        state_q <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    // An older packet takes precedence over a head match on the
                    // stale entry. The held load is no longer the one to flush.
                    if (ldVioValid_i && in_older_d) begin
                        seq_q  <= ldVioSeqNo_i;
                        alid_q <= ldVioAlID_i;
                    end else if (head_match_d) begin
                        req_q   <= 1'b1;
                        state_q <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_WAIT_REC;
                end
                ST_WAIT_REC: begin
                    state_q <= ST_WAIT_REC;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // alid_q is cleared whenever IDLE is entered, so it already reads 0 there.
    assign violateValid_o = valid_q;
    assign violateAlID_o  = alid_q;
    assign recoverReq_o   = req_q;
    assign vioCount_o     = cnt_q;

endmodule

// File: tb/tb_ld_violation_tracker.sv
module tb_ld_violation_tracker;

    localparam int SEQ_W = 8;
    localparam int AL_W  = 7;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             recoverFlag_i;
    logic             ldVioValid_i;
    logic [SEQ_W-1:0] ldVioSeqNo_i;
    logic [AL_W-1:0]  ldVioAlID_i;
    logic [AL_W-1:0]  headAlID_i;
    logic             headReady_i;
    logic             violateValid_o;
    logic [AL_W-1:0]  violateAlID_o;
    logic             recoverReq_o;
    logic [CNT_W-1:0] vioCount_o;

    // A narrow-counter copy shares all inputs and only exercises saturation.
    logic             s_valid;
    logic [AL_W-1:0]  s_alid;
    logic             s_req;
    logic [1:0]       s_cnt;

    ld_violation_tracker #(.SEQ_W(SEQ_W), .AL_W(AL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .ldVioValid_i(ldVioValid_i), .ldVioSeqNo_i(ldVioSeqNo_i),
        .ldVioAlID_i(ldVioAlID_i), .headAlID_i(headAlID_i),
        .headReady_i(headReady_i), .violateValid_o(violateValid_o),
        .violateAlID_o(violateAlID_o), .recoverReq_o(recoverReq_o),
        .vioCount_o(vioCount_o)
    );

    ld_violation_tracker #(.SEQ_W(SEQ_W), .AL_W(AL_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .ldVioValid_i(ldVioValid_i), .ldVioSeqNo_i(ldVioSeqNo_i),
        .ldVioAlID_i(ldVioAlID_i), .headAlID_i(headAlID_i),
        .headReady_i(headReady_i), .violateValid_o(s_valid),
        .violateAlID_o(s_alid), .recoverReq_o(s_req),
        .vioCount_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int alid;
        bit req;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what is being tracked and what phase the recovery is in.
    typedef enum {M_NONE, M_TRACK, M_REQ, M_AWAIT} phase_t;
    phase_t m_phase = M_NONE;
    int     m_seq   = 0;
    int     m_al    = 0;
    int     m_cnt   = 0;

    function automatic bit is_older(int a, int b);
        return (((a - b) % 256 + 256) % 256) >= 128;
    endfunction

    task automatic step(bit rst, bit rf, bit v, int s, int a, bit hr, int ha);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        recoverFlag_i = rf;
        ldVioValid_i  = v;
        ldVioSeqNo_i  = SEQ_W'(s);
        ldVioAlID_i   = AL_W'(a);
        headReady_i   = hr;
        headAlID_i    = AL_W'(ha);
        if (rst) begin
            m_phase = M_NONE; m_seq = 0; m_al = 0; m_cnt = 0;
        end else if (rf) begin
            m_phase = M_NONE; m_seq = 0; m_al = 0;
        end else begin
            if (v && m_cnt < 65535) m_cnt++;
            case (m_phase)
                M_NONE:  if (v) begin m_seq = s; m_al = a; m_phase = M_TRACK; end
                M_TRACK: begin
                    if (v && is_older(s, m_seq)) begin m_seq = s; m_al = a; end
                    else if (hr && ha == m_al) m_phase = M_REQ;
                end
                M_REQ:   m_phase = M_AWAIT;
                default: m_phase = M_AWAIT;
            endcase
        end
        e.valid = (m_phase != M_NONE);
        e.alid  = (m_phase == M_NONE) ? 0 : m_al;
        e.req   = (m_phase == M_REQ);
        e.cnt   = m_cnt;
        e.cnt2  = (m_cnt > 3) ? 3 : m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pkt(int s, int a);
        step(0, 0, 1, s, a, 0, 0);
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("violateValid", int'(violateValid_o), int'(e.valid));
                check("violateAlID",  int'(violateAlID_o),  e.alid);
                check("recoverReq",   int'(recoverReq_o),   int'(e.req));
                check("vioCount",     int'(vioCount_o),     e.cnt);
                check("vioCount_sat", int'(s_cnt),          e.cnt2);
                check("sat_valid",    int'(s_valid),        int'(e.valid));
                check("sat_req",      int'(s_req),          int'(e.req));
            end
        end
    end

    initial begin
        int wait_cyc;
        int ha;
        reset = 1; recoverFlag_i = 0; ldVioValid_i = 0; ldVioSeqNo_i = '0;
        ldVioAlID_i = '0; headAlID_i = '0; headReady_i = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // basic capture, fire, wait for recovery
        pkt(10, 5);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 1, 5);
        idle(3);
        step(0, 0, 1, 9, 2, 1, 2);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // older replaces, younger and equal dropped but counted
        pkt(20, 8);
        pkt(15, 3);
        pkt(30, 9);
        pkt(15, 6);
        step(0, 1, 0, 0, 0, 0, 0);

        // wrap-around ordering
        pkt(250, 1);
        pkt(3, 2);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0);
        pkt(3, 2);
        pkt(250, 1);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0);

        // packet squashed by recovery, older packet beats a head match
        pkt(40, 4);
        step(0, 1, 1, 1, 7, 0, 0);
        idle(1);
        pkt(40, 4);
        step(0, 0, 1, 39, 11, 1, 4);
        step(0, 0, 0, 0, 0, 1, 11);

        // reset in the middle of FIRE
        step(1, 0, 0, 0, 0, 0, 0);
        pkt(7, 6);
        step(0, 0, 0, 0, 0, 1, 6);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // saturation of the narrow counter
        for (int i = 0; i < 5; i++) pkt(50 + i, i);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ha = (m_phase == M_TRACK && $urandom_range(0, 2) == 0) ? m_al
                                                                   : int'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < ((m_phase == M_AWAIT) ? 25 : 3)),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1),
                 ha);
        end
        idle(2);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ld_violation_tracker.md
Name: ld_violation_tracker

Overview:
- Sits directly downstream of the memory-lane writeback stage.
- Consumes the registered load-violation packet that stage emits and holds the oldest outstanding violation, ordered by sequence number with wrap-around.
- Raises a one-cycle recovery request once that instruction reaches the active-list head and is ready to commit.
- Holds off further requests until the core's recovery flag is seen; keeps a saturating violation count for performance counters.

Parameters:
- SEQ_W, 8, width of the sequence number (wraps modulo 2^SEQ_W).
- AL_W, 7, width of an active-list index (alID).
- CNT_W, 16, width of the saturating violation counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- recoverFlag_i  in  1  core-wide recovery in progress; flushes all tracked state.
- ldVioValid_i  in  1  load-violation packet valid, from the writeback stage output.
- ldVioSeqNo_i  in  SEQ_W  sequence number of the violating load.
- ldVioAlID_i  in  AL_W  active-list index of the violating load.
- headAlID_i  in  AL_W  alID currently at the active-list head.
- headReady_i  in  1  head entry is executed and would commit this cycle.
- violateValid_o  out  1  a violation is being tracked (state HELD, FIRE or WAIT_REC).
- violateAlID_o  out  AL_W  alID of the tracked violation.
- recoverReq_o  out  1  one-cycle pulse requesting a load-violation flush.
- vioCount_o  out  CNT_W  saturating count of accepted violation packets.

Behaviour:
- All state registers update on posedge clk.
- Reset (any cycle, including mid-FIRE or mid-WAIT_REC):
  - state=IDLE.
  - Held seqNo/alID cleared to 0.
  - All outputs 0, vioCount_o=0.
- Age compare: A is older than B iff (A-B) mod 2^SEQ_W has MSB set; equal seqNo is not older.
- States:
  - IDLE: no violation tracked.
    - ldVioValid_i -> capture seqNo/alID, go to HELD.
  - HELD: violateValid_o=1.
    - If ldVioValid_i and the incoming seqNo is older than the held one -> replace the held seqNo/alID, stay HELD, no fire this cycle.
    - Otherwise, if headReady_i and headAlID_i==held alID -> go to FIRE.
    - A younger or equal incoming packet is dropped but still counted.
  - FIRE: recoverReq_o=1 for exactly this cycle.
    - Next state is WAIT_REC unconditionally.
    - Incoming packets are counted, not tracked.
  - WAIT_REC: recoverReq_o=0, violateValid_o=1.
    - Incoming packets are counted, not tracked.
    - Stays here until recoverFlag_i.
- recoverFlag_i (priority below reset, above everything else; any state):
  - Next state=IDLE, held fields cleared.
  - A same-cycle ldVioValid_i is discarded and not counted.
  - vioCount_o is preserved.
- Latency:
  - A packet on cycle N is visible on violateValid_o/violateAlID_o at N+1.
  - A head match in HELD on cycle N gives recoverReq_o high during N+1 only.
  - Minimum time from packet arrival to recoverReq_o is 2 cycles.
- Counter:
  - Increments by 1 on every ldVioValid_i that is not squashed by reset or recoverFlag_i.
  - Saturates at 2^CNT_W-1 and never wraps.
- violateAlID_o outputs the held alID and is 0 in IDLE.
- Outputs are driven only from registers, with no combinational input-to-output path.

Test Plan:
- Reset, then packet seq=10, alID=5 -> next cycle violateValid_o=1, violateAlID_o=5, vioCount_o=1, recoverReq_o=0.
- Held (seq=10, alID=5); headAlID_i=5 with headReady_i=1 for one cycle -> recoverReq_o=1 for exactly one cycle. After that, violateValid_o stays 1 until recoverFlag_i, then the block returns to IDLE with all outputs 0 except vioCount_o.
- Held seq=20/alID=8; packet seq=15/alID=3 -> tracked alID becomes 3. A later packet seq=30 is ignored for tracking, and vioCount_o=3.
- Wrap, SEQ_W=8: held seq=250; packet seq=3 -> still 250 (since 3 is younger). Held seq=3; packet seq=250 -> replaced by 250.
- Same cycle packet seq=1 and recoverFlag_i=1 while in HELD -> IDLE, count unchanged. Reset asserted during FIRE -> recoverReq_o=0 the next cycle and vioCount_o=0.
- CNT_W=2 with 5 accepted packets -> vioCount_o sticks at 3.
